dmem_mp: RTL and testbench
==========================

// Module: dmem_mp
// PURPOSE
//  Parametrised multi-port data memory for the superscalar pipeline; replaces the fixed 4R/2W dmem.
//  NRD synchronous read ports, NWR write ports with byte enables, and deterministic same-word write ordering.
//  Self-clears the array after reset through a sweep FSM.
//  Sits in the MEM stage; one read port and one write port per issue slot (port index = slot age, 0 oldest).
// PARAMETERS
//  DATA_W  32  data width, multiple of 8; byte lanes BL = DATA_W/8
//  ADDR_W  32  byte-address width
//  DEPTH   32  words in array; IDX_W = $clog2(DEPTH); word index = addr[2 +: IDX_W]
//  NRD     4   read ports
//  NWR     2   write ports
// PORTS
//  clk      in   1          clock, all state on posedge
//  reset_n  in   1          asynchronous, active-low reset
//  rd_en    in   NRD        per-port read enable
//  rd_addr  in   NRD*ADDR_W byte addresses, port j at [j*ADDR_W +: ADDR_W]
//  rd_data  out  NRD*DATA_W registered read data
//  we       in   NWR        per-port write enable
//  wr_addr  in   NWR*ADDR_W byte addresses
//  wr_be    in   NWR*BL     byte enables (bit b -> data[8b+:8])
//  wr_data  in   NWR*DATA_W write data
//  ready    out  1          1 = array cleared, accesses honoured
//  oor_err  out  1          sticky: enabled access out of range
// BEHAVIOUR
//  Reset (async assert, reset_n=0): state=CLEAR, clr_idx=0, rd_data=0, ready=0, oor_err=0. Array contents not reset directly.
//  CLEAR: each cycle RAM[clr_idx]<=0, clr_idx++.
//   - At clr_idx==DEPTH-1: state->READY, ready=1 on next cycle; sweep takes exactly DEPTH cycles.
//   - we ignored; rd_data held at 0; oor_err not updated.
//  READY: terminal until reset.
//   - reset_n low mid-sweep or in READY restarts CLEAR from idx 0.
//  Out of range = addr[2+:IDX_W] >= DEPTH, or addr[ADDR_W-1:2+IDX_W] != 0.
//   - Low 2 addr bits ignored (word aligned).
//  Write (READY, we[i]=1, in range): at posedge, byte b of RAM[idx] <= wr_data byte b where wr_be[i][b]=1.
//   - Other lanes keep old value. we[i] with wr_be=0 is a no-op.
//  Same-word collision: resolved per byte lane; the highest-indexed (youngest) enabled port wins.
//   - Lanes not enabled by any port are unchanged.
//  Read (READY, rd_en[j]=1): rd_data[j] <= RAM[idx] at posedge, 1-cycle latency.
//   - rd_en=0: rd_data[j] holds its previous value.
//   - Out-of-range read loads 0.
//  Out-of-range write: dropped.
//  oor_err: set on posedge when any enabled read/write is out of range in READY; clears only on reset.
//  Read/write same word, same cycle: see CONFIGURATION.
// CONFIGURATION
//  DMEM_FWD_EN defined: write-first.
//   - rd_data gets the fully merged post-write word, collision rule applied.
//   - Forwarding mux per read port, comb from wr_* ports.
//  DMEM_FWD_EN undefined: read-first; rd_data gets the pre-write word.
//  All other behaviour is identical in both builds.
// TESTING
//  1. reset_n low 3 cycles then high; DEPTH=32 -> ready=0 cycles 0..31, ready=1 at cycle 32; all 32 words read 0.
//  2. Write port0 addr 0x8, be=4'b1111, data 0xDEADBEEF; next cycle port1 addr 0x8, be=4'b0001, data 0x55.
//     Read addr 0x8 one cycle later -> 0xDEADBE55.
//  3. Same cycle: port0 addr 0x10 be=1111 data 0x11111111, port1 addr 0x10 be=0011 data 0x2222.
//     Subsequent read -> 0x11112222 (youngest wins lanes 0-1).
//  4. RAM[4]=0xAAAA0000; same cycle: write 0x12345678 to 0x10 be=1111 and rd_en port2 at 0x10.
//     FWD_EN -> rd_data[2]=0x12345678; without FWD_EN -> 0xAAAA0000.
//     Next read of 0x10 -> 0x12345678 in both builds.
//  5. Read 0x200 (idx 128 >= 32) -> rd_data=0, oor_err=1 and stays 1.
//     Write 0x200 -> no array change. Reset clears oor_err.
//  6. Assert reset_n low at sweep cycle 10, release -> ready rises 32 cycles after release.
//     Writes issued during CLEAR are lost (word reads 0).

Source files
------------

// File: rtl/dmem_mp_if.sv
// rtl/dmem_mp_if.sv - read/write port bundle for the multi-port data memory
interface dmem_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2
);
    localparam int BL = DATA_W / 8;

    logic [NRD-1:0]        rd_en;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] wr_addr;
    logic [NWR*BL-1:0]     wr_be;
    logic [NWR*DATA_W-1:0] wr_data;
    logic                  ready;
    logic                  oor_err;

    modport master (
        output rd_en, rd_addr, we, wr_addr, wr_be, wr_data,
        input  rd_data, ready, oor_err
    );

    modport slave (
        input  rd_en, rd_addr, we, wr_addr, wr_be, wr_data,
        output rd_data, ready, oor_err
    );
endinterface

// File: rtl/dmem_mp.sv
// rtl/dmem_mp.sv - multi-port data memory with self-clearing sweep (optional DMEM_FWD_EN write-first)
module dmem_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    dmem_mp_if.slave   bus
);
    localparam int BL    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W + 1)'(DEPTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] clr_idx;
    logic             clr_we;
    logic             acc_en;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] ra      [NRD];
    logic [ADDR_W-1:0] wa      [NWR];
    logic [NRD-1:0]    rd_in;
    logic [NWR-1:0]    wr_in;
    logic [NWR-1:0]    wr_ok;
    logic              oor_hit;
    logic [DATA_W-1:0] rd_word [NRD];

    logic [NRD*DATA_W-1:0] rd_q;
    logic                  oor_q;

    // Word index ignores the two byte-offset bits.
    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
        return a[2 +: IDX_W];
    endfunction

    // In range: nothing above the index field, and the index inside the array.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [IDX_W:0] idx_ext;
        idx_ext = {1'b0, a[2 +: IDX_W]};
        return ((a >> (2 + IDX_W)) == '0) && (idx_ext < DEPTH_X);
    endfunction

    // State register and clear-sweep index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nx;
            if (clr_we) begin
                clr_idx <= clr_idx + IDX_W'(1);
            end
        end
    end

    // Next state: leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_nx = state;
        if (state == S_CLEAR && clr_idx == LAST_IDX) begin
            state_nx = S_READY;
        end
    end

    // FSM outputs: sweep write strobe while clearing, port access once ready.
    always_comb begin
        clr_we = (state == S_CLEAR);
        acc_en = (state == S_READY);
    end

    // Address decode and range check for every port.
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            ra[j]    = bus.rd_addr[j*ADDR_W +: ADDR_W];
            rd_in[j] = in_range(ra[j]);
        end
        for (int i = 0; i < NWR; i++) begin
            wa[i]    = bus.wr_addr[i*ADDR_W +: ADDR_W];
            wr_in[i] = in_range(wa[i]);
            wr_ok[i] = acc_en && bus.we[i] && wr_in[i];
        end
        oor_hit = acc_en && (((bus.rd_en & ~rd_in) != '0) || ((bus.we & ~wr_in) != '0));
    end

    // Array update: sweep zeroing, else byte-lane writes applied oldest to youngest so the youngest port wins.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                for (int b = 0; b < BL; b++) begin
                    if (wr_ok[i] && bus.wr_be[i*BL + b]) begin
                        mem[widx(wa[i])][8*b +: 8] <= bus.wr_data[i*DATA_W + 8*b +: 8];
                    end
                end
            end
        end
    end

    // Read word per port: array word (or merged post-write word when forwarding), zero when out of range.
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd_word[j] = '0;
            if (rd_in[j]) begin
                rd_word[j] = mem[widx(ra[j])];
`ifdef DMEM_FWD_EN
                for (int i = 0; i < NWR; i++) begin
                    for (int b = 0; b < BL; b++) begin
                        if (wr_ok[i] && bus.wr_be[i*BL + b] && widx(wa[i]) == widx(ra[j])) begin
                            rd_word[j][8*b +: 8] = bus.wr_data[i*DATA_W + 8*b +: 8];
                        end
                    end
                end
`endif
            end
        end
    end

    // Registered read data; disabled ports hold, nothing loads while clearing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (acc_en) begin
            for (int j = 0; j < NRD; j++) begin
                if (bus.rd_en[j]) begin
                    rd_q[j*DATA_W +: DATA_W] <= rd_word[j];
                end
            end
        end
    end

    // Sticky out-of-range flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oor_q <= 1'b0;
        end else if (oor_hit) begin
            oor_q <= 1'b1;
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.ready   = acc_en;
    assign bus.oor_err = oor_q;
endmodule

// File: tb/tb_dmem_mp.sv
// tb/tb_dmem_mp.sv - randomized self-checking bench for dmem_mp against a reference model
module tb_dmem_mp;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int BL    = DW / 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) bus ();

    dmem_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rd  [NRD];
    logic          m_oor;
    int            m_cnt;

    // Staged stimulus for the next clock edge
    logic [NRD-1:0] s_re;
    logic [AW-1:0]  s_ra [NRD];
    logic [NWR-1:0] s_we;
    logic [AW-1:0]  s_wa [NWR];
    logic [BL-1:0]  s_be [NWR];
    logic [DW-1:0]  s_wd [NWR];

    function automatic bit inr(input logic [AW-1:0] a);
        return (a >> 2) < DEPTH;
    endfunction

    task automatic idle();
        s_re = '0;
        s_we = '0;
        for (int j = 0; j < NRD; j++) s_ra[j] = '0;
        for (int i = 0; i < NWR; i++) begin
            s_wa[i] = '0;
            s_be[i] = '0;
            s_wd[i] = '0;
        end
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [BL-1:0] be, input logic [DW-1:0] d);
        s_we[p] = 1'b1;
        s_wa[p] = a;
        s_be[p] = be;
        s_wd[p] = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        s_re[p] = 1'b1;
        s_ra[p] = a;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_oor = 1'b0;
        for (int j = 0; j < NRD; j++) m_rd[j] = '0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    endtask

    // Drive staged inputs, advance the model one edge, then compare every output.
    task automatic cycle();
        logic [DW-1:0] old_mem [DEPTH];
        int idx;
        bus.rd_en = s_re;
        bus.we    = s_we;
        for (int j = 0; j < NRD; j++) bus.rd_addr[j*AW +: AW] = s_ra[j];
        for (int i = 0; i < NWR; i++) begin
            bus.wr_addr[i*AW +: AW] = s_wa[i];
            bus.wr_be[i*BL +: BL]   = s_be[i];
            bus.wr_data[i*DW +: DW] = s_wd[i];
        end
        if (m_cnt >= DEPTH) begin
            old_mem = m_mem;
            for (int i = 0; i < NWR; i++) begin
                if (s_we[i]) begin
                    if (inr(s_wa[i])) begin
                        idx = int'(s_wa[i] >> 2);
                        for (int b = 0; b < BL; b++)
                            if (s_be[i][b]) m_mem[idx][8*b +: 8] = s_wd[i][8*b +: 8];
                    end else begin
                        m_oor = 1'b1;
                    end
                end
            end
            for (int j = 0; j < NRD; j++) begin
                if (s_re[j]) begin
                    if (inr(s_ra[j])) begin
                        idx = int'(s_ra[j] >> 2);
`ifdef DMEM_FWD_EN
                        m_rd[j] = m_mem[idx];
`else
                        m_rd[j] = old_mem[idx];
`endif
                    end else begin
                        m_rd[j] = '0;
                        m_oor   = 1'b1;
                    end
                end
            end
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        check("ready", 64'(bus.ready), 64'(m_cnt >= DEPTH));
        check("oor_err", 64'(bus.oor_err), 64'(m_oor));
        for (int j = 0; j < NRD; j++)
            check($sformatf("rd_data%0d", j), 64'(bus.rd_data[j*DW +: DW]), 64'(m_rd[j]));
    endtask

    task automatic do_reset(input int hold);
        idle();
        bus.rd_en = '0;
        bus.we    = '0;
        reset_n   = 1'b0;
        model_reset();
        repeat (hold) @(negedge clk);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_oor", 64'(bus.oor_err), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check(tag, 64'(n), 64'(DEPTH));
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int r;
        int k;
        r = $urandom_range(0, 99);
        if (r < 2) return AW'(32'h200 + ($urandom_range(0, 3) << 2));
        if (r == 2) return AW'(32'h8000_0000 | ($urandom_range(0, 31) << 2));
        k = $urandom_range(0, 8);
        if (k == 8) k = DEPTH - 1;
        return AW'((k << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        bus.rd_en   = '0;
        bus.rd_addr = '0;
        bus.we      = '0;
        bus.wr_addr = '0;
        bus.wr_be   = '0;
        bus.wr_data = '0;
        @(negedge clk);

        // Reset, sweep latency, every word reads zero
        do_reset(3);
        wait_ready("ready_lat");
        for (int k = 0; k < DEPTH; k++) begin
            idle();
            rd(k % NRD, AW'(4 * k));
            cycle();
            check("clr_word", 64'(bus.rd_data[(k % NRD)*DW +: DW]), 64'd0);
        end

        // Byte-enable merge across consecutive cycles
        idle(); wr(0, 32'h8, 4'b1111, 32'hDEADBEEF); cycle();
        idle(); wr(1, 32'h8, 4'b0001, 32'h55); cycle();
        idle(); rd(0, 32'h8); cycle();
        check("be_merge", 64'(bus.rd_data[0 +: DW]), 64'h0000_0000_DEAD_BE55);

        // Same-word collision: youngest port wins its lanes
        idle(); wr(0, 32'h10, 4'b1111, 32'h11111111); wr(1, 32'h10, 4'b0011, 32'h2222); cycle();
        idle(); rd(0, 32'h10); cycle();
        check("collide", 64'(bus.rd_data[0 +: DW]), 64'h0000_0000_1111_2222);

        // Read and write of the same word in the same cycle
        idle(); wr(0, 32'h10, 4'b1111, 32'hAAAA0000); cycle();
        idle(); wr(0, 32'h10, 4'b1111, 32'h12345678); rd(2, 32'h10); cycle();
`ifdef DMEM_FWD_EN
        check("rw_same", 64'(bus.rd_data[2*DW +: DW]), 64'h0000_0000_1234_5678);
`else
        check("rw_same", 64'(bus.rd_data[2*DW +: DW]), 64'h0000_0000_AAAA_0000);
`endif
        idle(); rd(2, 32'h10); cycle();
        check("rw_after", 64'(bus.rd_data[2*DW +: DW]), 64'h0000_0000_1234_5678);

        // Out-of-range read and write; write to 0x200 must not alias word 0
        idle(); rd(1, 32'h200); cycle();
        check("oor_rd_data", 64'(bus.rd_data[1*DW +: DW]), 64'd0);
        check("oor_set", 64'(bus.oor_err), 64'd1);
        idle(); cycle();
        check("oor_sticky", 64'(bus.oor_err), 64'd1);
        idle(); wr(0, 32'h200, 4'b1111, 32'hFFFFFFFF); cycle();
        idle(); rd(3, 32'h0); cycle();
        check("oor_no_write", 64'(bus.rd_data[3*DW +: DW]), 64'd0);
        do_reset(2);
        wait_ready("ready_lat2");

        // Reset mid-sweep restarts it; writes during the sweep are lost
        do_reset(2);
        for (int c = 0; c < 10; c++) begin
            idle(); wr(0, 32'h14, 4'b1111, 32'hCAFEF00D); cycle();
        end
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int n;
            n = 0;
            while (bus.ready !== 1'b1 && n < 100) begin
                idle(); wr(1, 32'h14, 4'b1111, 32'h0BADBEEF);
                cycle();
                n++;
            end
            check("ready_restart", 64'(n), 64'(DEPTH));
        end
        idle(); rd(0, 32'h14); cycle();
        check("clear_wr_lost", 64'(bus.rd_data[0 +: DW]), 64'd0);

        // Randomized traffic against the model
        for (int round = 0; round < 3; round++) begin
            do_reset(2);
            idle();
            wait_ready("ready_lat_rnd");
            for (int c = 0; c < 150; c++) begin
                idle();
                for (int j = 0; j < NRD; j++) begin
                    s_re[j] = 1'($urandom_range(0, 1));
                    s_ra[j] = rnd_addr();
                end
                for (int i = 0; i < NWR; i++) begin
                    s_we[i] = 1'($urandom_range(0, 1));
                    s_wa[i] = rnd_addr();
                    s_be[i] = BL'($urandom_range(0, 15));
                    s_wd[i] = DW'($urandom);
                end
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
